// File: rtl/dallan_pkg.sv
// dallan_pkg: shared widths, queue-entry record and controller states
package dallan_pkg;
  localparam int PS_GENISLIK = 32;
  localparam int BUYRUK_ADIM = 4;
  typedef struct packed {
    logic [PS_GENISLIK-1:0] ps;
    logic                   dallan;
    logic [PS_GENISLIK-1:0] hedef;
  } girdi_t;
  typedef enum logic {NORMAL, TEMIZLE} durum_t;
endpackage

// File: rtl/ongoru_kuyrugu.sv
// ongoru_kuyrugu: in-order FIFO of outstanding predictions
// ports: clk, rst (async), push/pop/clear controls, giris entry in, bas head out, dolu/bos flags
module ongoru_kuyrugu
  import dallan_pkg::*;
#(
  parameter int DERINLIK = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  logic   clear,
  input  girdi_t giris,
  output girdi_t bas,
  output logic   dolu,
  output logic   bos
);
  localparam int AW = $clog2(DERINLIK);
  logic [AW:0] yaz, oku;
  girdi_t mem [DERINLIK];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      yaz <= '0;
      oku <= '0;
    end else if (clear) begin
      yaz <= '0;
      oku <= '0;
    end else begin
      if (push) yaz <= yaz + 1'b1;
      if (pop) oku <= oku + 1'b1;
    end
  always_ff @(posedge clk)
    if (push && !clear) mem[yaz[AW-1:0]] <= giris;
  assign bas  = mem[oku[AW-1:0]];
  assign bos  = yaz == oku;
  // the extra wrap bit tells full from empty when the indices match
  assign dolu = yaz == {~oku[AW], oku[AW-1:0]};
endmodule

// File: rtl/dallan_denetleyici.sv
// dallan_denetleyici: checks queued branch predictions against execute, flushes/redirects, trains predictor
// ports: fetch push (getir_*), execute resolve (yurut_*), flush/redirect (temizle, yonlendir_*),
//        table write (tablo_yaz_*), yanlis_sayac saturating mispredict count, hata sticky error
module dallan_denetleyici
  import dallan_pkg::*;
#(
  parameter int KUYRUK_DERINLIK = 4,
  parameter int TEMIZLE_CEVRIM  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        getir_gecerli,
  input  logic [31:0] getir_ps,
  input  logic        ongoru_dallan,
  input  logic [31:0] ongoru_ps,
  output logic        getir_hazir,
  input  logic        yurut_gecerli,
  input  logic [31:0] yurut_ps,
  input  logic        yurut_dallan,
  input  logic [31:0] yurut_dallan_ps,
  output logic        temizle,
  output logic        yonlendir_gecerli,
  output logic [31:0] yonlendir_ps,
  output logic        tablo_yaz,
  output logic [31:0] tablo_yaz_ps,
  output logic        tablo_yaz_dallan,
  output logic [31:0] tablo_yaz_hedef,
  output logic [15:0] yanlis_sayac,
  output logic        hata
);
  localparam int SW = $clog2(TEMIZLE_CEVRIM + 1);
  durum_t durum, durum_n;
  logic [SW-1:0] sayac, sayac_n;
  logic push, pop, yanlis, ps_hata, bos, dolu;
  girdi_t bas, yeni;
  logic [PS_GENISLIK-1:0] hedef_ps;
  assign getir_hazir = durum == NORMAL && !dolu;
  assign push        = getir_gecerli && getir_hazir;
  assign pop         = yurut_gecerli && durum == NORMAL && !bos;
  assign ps_hata     = yurut_ps != bas.ps;
  assign yanlis      = pop && (yurut_dallan != bas.dallan || ps_hata ||
                       (yurut_dallan && bas.dallan && yurut_dallan_ps != bas.hedef));
  assign hedef_ps    = yurut_dallan ? yurut_dallan_ps : yurut_ps + PS_GENISLIK'(BUYRUK_ADIM);
  assign yeni        = '{ps: getir_ps, dallan: ongoru_dallan, hedef: ongoru_ps};
  ongoru_kuyrugu #(.DERINLIK(KUYRUK_DERINLIK)) u_kuyruk (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .clear(yanlis),
    .giris(yeni), .bas(bas), .dolu(dolu), .bos(bos)
  );
  // flush hold-off: TEMIZLE lasts exactly TEMIZLE_CEVRIM cycles
  always_comb begin
    durum_n = yanlis ? TEMIZLE : (durum == TEMIZLE && sayac == '0) ? NORMAL : durum;
    sayac_n = yanlis ? SW'(TEMIZLE_CEVRIM - 1) : (durum == TEMIZLE && sayac != '0) ? sayac - 1'b1 : sayac;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      durum             <= NORMAL;
      sayac             <= '0;
      temizle           <= 1'b0;
      yonlendir_gecerli <= 1'b0;
      yonlendir_ps      <= '0;
      tablo_yaz         <= 1'b0;
      tablo_yaz_ps      <= '0;
      tablo_yaz_dallan  <= 1'b0;
      tablo_yaz_hedef   <= '0;
      yanlis_sayac      <= '0;
      hata              <= 1'b0;
    end else begin
      durum             <= durum_n;
      sayac             <= sayac_n;
      temizle           <= yanlis;
      yonlendir_gecerli <= yanlis;
      yonlendir_ps      <= yanlis ? hedef_ps : '0;
      tablo_yaz         <= pop;
      tablo_yaz_ps      <= pop ? yurut_ps : '0;
      tablo_yaz_dallan  <= pop && yurut_dallan;
      tablo_yaz_hedef   <= pop ? yurut_dallan_ps : '0;
      yanlis_sayac      <= yanlis_sayac + 16'(yanlis && yanlis_sayac != 16'hFFFF);
      hata              <= hata || (yurut_gecerli && durum == NORMAL && bos) || (pop && ps_hata);
    end
endmodule

// File: tb/tb_dallan_denetleyici.sv
// tb_dallan_denetleyici: directed vector table plus reset and push-on-empty sequences
module tb_dallan_denetleyici;
  logic clk = 0, rst = 1;
  logic getir_gecerli = 0, ongoru_dallan = 0, yurut_gecerli = 0, yurut_dallan = 0;
  logic [31:0] getir_ps = 0, ongoru_ps = 0, yurut_ps = 0, yurut_dallan_ps = 0;
  logic getir_hazir, temizle, yonlendir_gecerli, tablo_yaz, tablo_yaz_dallan, hata;
  logic [31:0] yonlendir_ps, tablo_yaz_ps, tablo_yaz_hedef;
  logic [15:0] yanlis_sayac;
  int checks = 0, failures = 0;

  dallan_denetleyici #(.KUYRUK_DERINLIK(4), .TEMIZLE_CEVRIM(2)) dut (
    .clk(clk), .rst(rst),
    .getir_gecerli(getir_gecerli), .getir_ps(getir_ps), .ongoru_dallan(ongoru_dallan),
    .ongoru_ps(ongoru_ps), .getir_hazir(getir_hazir),
    .yurut_gecerli(yurut_gecerli), .yurut_ps(yurut_ps), .yurut_dallan(yurut_dallan),
    .yurut_dallan_ps(yurut_dallan_ps),
    .temizle(temizle), .yonlendir_gecerli(yonlendir_gecerli), .yonlendir_ps(yonlendir_ps),
    .tablo_yaz(tablo_yaz), .tablo_yaz_ps(tablo_yaz_ps), .tablo_yaz_dallan(tablo_yaz_dallan),
    .tablo_yaz_hedef(tablo_yaz_hedef), .yanlis_sayac(yanlis_sayac), .hata(hata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic gg; logic [31:0] gps; logic od; logic [31:0] ops;
    logic yg; logic [31:0] yps; logic yd; logic [31:0] ydps;
    logic e_hazir; logic e_yaz; logic [31:0] e_yaz_ps; logic e_tem;
    logic [31:0] e_yon; logic [15:0] e_say; logic e_hata;
  } vek_t;

  function automatic vek_t mk(logic gg, logic [31:0] gps, logic od, logic [31:0] ops,
                              logic yg, logic [31:0] yps, logic yd, logic [31:0] ydps,
                              logic h, logic y, logic [31:0] yp, logic tm, logic [31:0] rp,
                              logic [15:0] s, logic ht);
    vek_t v;
    v = '{gg, gps, od, ops, yg, yps, yd, ydps, h, y, yp, tm, rp, s, ht};
    return v;
  endfunction

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, a, e);
    end
  endtask

  task automatic drive(logic gg, logic [31:0] gps, logic od, logic [31:0] ops,
                       logic yg, logic [31:0] yps, logic yd, logic [31:0] ydps);
    getir_gecerli = gg; getir_ps = gps; ongoru_dallan = od; ongoru_ps = ops;
    yurut_gecerli = yg; yurut_ps = yps; yurut_dallan = yd; yurut_dallan_ps = ydps;
  endtask

  task automatic chk_zero(string n);
    chk({n, "_tablo_yaz"}, 32'(tablo_yaz), 0);
    chk({n, "_tablo_ps"}, tablo_yaz_ps, 0);
    chk({n, "_tablo_dallan"}, 32'(tablo_yaz_dallan), 0);
    chk({n, "_tablo_hedef"}, tablo_yaz_hedef, 0);
    chk({n, "_temizle"}, 32'(temizle), 0);
    chk({n, "_yon_gecerli"}, 32'(yonlendir_gecerli), 0);
    chk({n, "_yon_ps"}, yonlendir_ps, 0);
    chk({n, "_sayac"}, 32'(yanlis_sayac), 0);
    chk({n, "_hata"}, 32'(hata), 0);
  endtask

  vek_t t[28];

  initial begin
    t[0]  = mk(1, 32'h100, 1, 32'h200, 0, 0, 0, 0,                1, 0, 0, 0, 0, 0, 0);
    t[1]  = mk(0, 0, 0, 0, 1, 32'h100, 1, 32'h200,                1, 1, 32'h100, 0, 0, 0, 0);
    t[2]  = mk(1, 32'h40, 1, 32'h80, 0, 0, 0, 0,                  1, 0, 0, 0, 0, 0, 0);
    t[3]  = mk(1, 32'h44, 0, 0, 0, 0, 0, 0,                       1, 0, 0, 0, 0, 0, 0);
    t[4]  = mk(1, 32'h48, 0, 0, 0, 0, 0, 0,                       1, 0, 0, 0, 0, 0, 0);
    t[5]  = mk(1, 32'h4C, 0, 0, 1, 32'h40, 0, 0,                  0, 1, 32'h40, 1, 32'h44, 1, 0);
    t[6]  = mk(0, 0, 0, 0, 1, 32'h999, 0, 0,                      0, 0, 0, 0, 0, 1, 0);
    t[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0,                            1, 0, 0, 0, 0, 1, 0);
    t[8]  = mk(1, 32'h200, 1, 32'h300, 0, 0, 0, 0,                1, 0, 0, 0, 0, 1, 0);
    t[9]  = mk(0, 0, 0, 0, 1, 32'h200, 1, 32'h380,                0, 1, 32'h200, 1, 32'h380, 2, 0);
    t[10] = mk(0, 0, 0, 0, 0, 0, 0, 0,                            0, 0, 0, 0, 0, 2, 0);
    t[11] = mk(0, 0, 0, 0, 0, 0, 0, 0,                            1, 0, 0, 0, 0, 2, 0);
    t[12] = mk(1, 32'h10, 0, 0, 0, 0, 0, 0,                       1, 0, 0, 0, 0, 2, 0);
    t[13] = mk(1, 32'h14, 0, 0, 0, 0, 0, 0,                       1, 0, 0, 0, 0, 2, 0);
    t[14] = mk(1, 32'h18, 0, 0, 0, 0, 0, 0,                       1, 0, 0, 0, 0, 2, 0);
    t[15] = mk(1, 32'h1C, 0, 0, 0, 0, 0, 0,                       0, 0, 0, 0, 0, 2, 0);
    t[16] = mk(1, 32'h20, 0, 0, 1, 32'h10, 0, 0,                  1, 1, 32'h10, 0, 0, 2, 0);
    t[17] = mk(1, 32'h20, 0, 0, 1, 32'h14, 0, 0,                  1, 1, 32'h14, 0, 0, 2, 0);
    t[18] = mk(0, 0, 0, 0, 1, 32'h18, 0, 0,                       1, 1, 32'h18, 0, 0, 2, 0);
    t[19] = mk(0, 0, 0, 0, 1, 32'h1C, 0, 0,                       1, 1, 32'h1C, 0, 0, 2, 0);
    t[20] = mk(0, 0, 0, 0, 1, 32'h20, 0, 0,                       1, 1, 32'h20, 0, 0, 2, 0);
    t[21] = mk(0, 0, 0, 0, 1, 32'h24, 0, 0,                       1, 0, 0, 0, 0, 2, 1);
    t[22] = mk(1, 32'h10, 0, 0, 0, 0, 0, 0,                       1, 0, 0, 0, 0, 2, 1);
    t[23] = mk(0, 0, 0, 0, 1, 32'h14, 0, 0,                       0, 1, 32'h14, 1, 32'h18, 3, 1);
    t[24] = mk(0, 0, 0, 0, 0, 0, 0, 0,                            0, 0, 0, 0, 0, 3, 1);
    t[25] = mk(0, 0, 0, 0, 0, 0, 0, 0,                            1, 0, 0, 0, 0, 3, 1);
    t[26] = mk(1, 32'hFFFFFFFC, 1, 32'h500, 0, 0, 0, 0,           1, 0, 0, 0, 0, 3, 1);
    t[27] = mk(0, 0, 0, 0, 1, 32'hFFFFFFFC, 0, 0,                 0, 1, 32'hFFFFFFFC, 1, 0, 4, 1);

    rst = 1;
    @(posedge clk); #1;
    chk_zero("reset");
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    chk("reset_hazir", 32'(getir_hazir), 1);

    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      drive(t[i].gg, t[i].gps, t[i].od, t[i].ops, t[i].yg, t[i].yps, t[i].yd, t[i].ydps);
      @(posedge clk); #1;
      chk($sformatf("v%0d_hazir", i), 32'(getir_hazir), 32'(t[i].e_hazir));
      chk($sformatf("v%0d_tablo_yaz", i), 32'(tablo_yaz), 32'(t[i].e_yaz));
      chk($sformatf("v%0d_temizle", i), 32'(temizle), 32'(t[i].e_tem));
      chk($sformatf("v%0d_yon_gecerli", i), 32'(yonlendir_gecerli), 32'(t[i].e_tem));
      chk($sformatf("v%0d_sayac", i), 32'(yanlis_sayac), 32'(t[i].e_say));
      chk($sformatf("v%0d_hata", i), 32'(hata), 32'(t[i].e_hata));
      if (t[i].e_yaz) begin
        chk($sformatf("v%0d_tablo_ps", i), tablo_yaz_ps, t[i].e_yaz_ps);
        chk($sformatf("v%0d_tablo_dallan", i), 32'(tablo_yaz_dallan), 32'(t[i].yd));
        chk($sformatf("v%0d_tablo_hedef", i), tablo_yaz_hedef, t[i].ydps);
      end
      if (t[i].e_tem) chk($sformatf("v%0d_yon_ps", i), yonlendir_ps, t[i].e_yon);
    end

    // reset asserted while still in TEMIZLE must clear everything without a clock edge
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1;
    #1;
    chk_zero("midrst");
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    chk("midrst_hazir", 32'(getir_hazir), 1);

    // push into empty queue with same-cycle resolve: error flagged, push still lands
    @(negedge clk);
    drive(1, 32'h60, 0, 0, 1, 32'h60, 0, 0);
    @(posedge clk); #1;
    chk("pushempty_hata", 32'(hata), 1);
    chk("pushempty_tablo_yaz", 32'(tablo_yaz), 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 32'h60, 0, 0);
    @(posedge clk); #1;
    chk("pushempty_pop_yaz", 32'(tablo_yaz), 1);
    chk("pushempty_pop_ps", tablo_yaz_ps, 32'h60);
    chk("pushempty_pop_temizle", 32'(temizle), 0);
    chk("pushempty_hata_sticky", 32'(hata), 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dallan_denetleyici.md
# dallan_denetleyici

Branch-resolution controller between fetch, the `ongorucu` predictor and execute. It queues every prediction issued at fetch and checks each one in order against the outcome resolved in execute. On a misprediction it sequences a front-end flush and a PC redirect. It also schedules the predictor-table update write for every resolved branch.

## Interface
Parameters:
- `KUYRUK_DERINLIK`, default 4: number of outstanding predictions (power of two, ≥2).
- `TEMIZLE_CEVRIM`, default 2: cycles fetch is held off after a flush (≥1).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `getir_gecerli`  in  1  fetch issues a predicted instruction this cycle.
- `getir_ps`  in  32  PC of that instruction.
- `ongoru_dallan`  in  1  predicted taken.
- `ongoru_ps`  in  32  predicted target.
- `getir_hazir`  out  1  controller accepts a fetch push this cycle.
- `yurut_gecerli`  in  1  execute resolves the oldest outstanding prediction.
- `yurut_ps`  in  32  PC of the resolved instruction.
- `yurut_dallan`  in  1  actual taken.
- `yurut_dallan_ps`  in  32  actual target.
- `temizle`  out  1  one-cycle front-end flush.
- `yonlendir_gecerli`  out  1  redirect valid, same cycle as `temizle`.
- `yonlendir_ps`  out  32  redirect PC.
- `tablo_yaz`  out  1  predictor-table write strobe.
- `tablo_yaz_ps`  out  32  write index PC.
- `tablo_yaz_dallan`  out  1  outcome to train.
- `tablo_yaz_hedef`  out  32  target to train.
- `yanlis_sayac`  out  16  misprediction count, saturating.
- `hata`  out  1  sticky protocol error.

## Operation
- States: NORMAL and TEMIZLE. Reset state is NORMAL, queue empty, all outputs 0.
- Push:
  - `getir_hazir` = (state==NORMAL) && !full. It is derived from registers only.
  - A push occurs when `getir_gecerli && getir_hazir`.
  - A push stores {`getir_ps`, `ongoru_dallan`, `ongoru_ps`}.
- Pop:
  - A pop occurs when `yurut_gecerli`, state==NORMAL and the queue is non-empty.
  - `yurut_gecerli` on an empty queue sets `hata` and is otherwise ignored.
  - `yurut_gecerli` during TEMIZLE is ignored; it is wrong-path.
- Misprediction, evaluated against the head entry E. Any of the following is a misprediction:
  - `yurut_dallan` != E.dallan;
  - both taken and `yurut_dallan_ps` != E.hedef;
  - `yurut_ps` != E.ps. This case also sets `hata` and forces resynchronisation.
- Redirect PC = `yurut_dallan` ? `yurut_dallan_ps` : `yurut_ps`+4. The addition is 32-bit modulo 2^32, so 0xFFFFFFFC wraps to 0.
- Every pop, correct or not, writes the table:
  - `tablo_yaz_ps` = `yurut_ps`;
  - `tablo_yaz_dallan` = `yurut_dallan`;
  - `tablo_yaz_hedef` = `yurut_dallan_ps`.
- On a misprediction:
  - the queue is cleared (younger entries are wrong-path), overriding any same-cycle push;
  - state goes to TEMIZLE;
  - `yanlis_sayac` increments and saturates at 0xFFFF.
- TEMIZLE:
  - an internal counter runs `TEMIZLE_CEVRIM` cycles, then the state returns to NORMAL;
  - `getir_hazir`=0 throughout.
- Simultaneous push and pop on a non-empty, non-full queue: both take effect and occupancy is unchanged.
- Full queue with a same-cycle pop: no push, because `getir_hazir` is already 0.
- Push into an empty queue with a same-cycle `yurut_gecerli`: the push occurs and `hata` is set.
- `rst` mid-operation: the queue clears immediately, the state is NORMAL, all outputs are 0 and the counter is 0.

## Timing
- All outputs except `getir_hazir` are registered.
- Resolution sampled at edge N:
  - `tablo_yaz`, `temizle`, `yonlendir_gecerli` and `yonlendir_ps` are valid for exactly cycle N+1;
  - `temizle` and `yonlendir_gecerli` assert only on a misprediction.
- `getir_hazir` is low for cycles N+1 … N+`TEMIZLE_CEVRIM` and high again at N+`TEMIZLE_CEVRIM`+1, provided the queue is not full.
- Back-to-back correct resolutions give one `tablo_yaz` per cycle with no bubbles.
- Push-to-pop minimum latency: an entry pushed at edge N can be popped at edge N+1.

## Structure
- Package `dallan_pkg` holds:
  - `PS_GENISLIK`=32 and `BUYRUK_ADIM`=4;
  - the queue-entry struct {ps, dallan, hedef};
  - the state enum {NORMAL, TEMIZLE}.
- Sub-module `ongoru_kuyrugu`: a synchronous FIFO of entries with push, pop, clear, full, empty and head outputs.
  - Its clear has priority over push.
  - Pointers carry one extra wrap bit.

## Test plan
- Correct taken prediction:
  - push ps=0x100, dallan=1, hedef=0x200;
  - resolve with ps=0x100, taken, target 0x200;
  - required: `tablo_yaz`=1 next cycle, no `temizle`, counter=0.
- Direction mispredict:
  - push ps=0x40, dallan=1, plus two younger entries;
  - resolve not-taken;
  - required: next cycle `temizle`=1 and `yonlendir_ps`=0x44;
  - then the queue is empty, `getir_hazir`=0 for 2 cycles, and counter=1.
- Target mispredict:
  - predicted 0x300, actual taken 0x380;
  - required: `yonlendir_ps`=0x380.
- Full queue:
  - push 4 entries;
  - required: `getir_hazir`=0;
  - then pop one with push held: `getir_hazir` returns to 1 the cycle after.
- Errors:
  - `yurut_gecerli` on an empty queue → required: `hata`=1, no `tablo_yaz`;
  - PC mismatch 0x10 vs 0x14 → required: a flush.
- Wrap and reset:
  - ps=0xFFFFFFFC predicted taken, resolved not-taken → required: `yonlendir_ps`=0;
  - assert `rst` during TEMIZLE → required: all outputs 0 immediately.
